burst_mem_responder: RTL and testbench

BURST_MEM_RESPONDER -- requirements
Module: burst_mem_responder

---
 rtl/burst_mem_responder.sv | 66 ++++++
 tb/tb_burst_mem_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/burst_mem_responder.sv
// burst_mem_responder: line memory answering 4-beat read/write bursts after a fixed latency
module burst_mem_responder #(
  parameter int LINES   = 16,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [31:0] address_i,
  input  logic [63:0] burst_i,
  output logic [63:0] burst_o,
  output logic        resp_o,
  output logic        busy_o
);
  localparam int IW = $clog2(LINES);
  typedef enum logic [2:0] {IDLE, WAIT, RBURST, WBURST, DONE} state_t;
  state_t state, next;
  logic [IW-1:0] idx;
  logic wr_op;
  logic [3:0] wait_cnt;
  logic [1:0] beat;
  logic [63:0] mem [LINES][4];
  logic unused;
  assign unused = ^{address_i[4:0], address_i[31:5+IW]};
  always_comb begin
    next = state;
    resp_o = 1'b0;
    busy_o = state != IDLE;
    burst_o = '0;
    case (state)
      IDLE: if (read_i || write_i) next = LATENCY == 0 ? (read_i ? RBURST : WBURST) : WAIT;
      WAIT: if (wait_cnt == '0) next = wr_op ? WBURST : RBURST;
      RBURST, WBURST: begin
        resp_o = 1'b1;
        burst_o = state == RBURST ? mem[idx][beat] : '0;
        if (beat == 2'd3) next = DONE;
      end
      default: next = IDLE;
    endcase
  end
  // read wins when both requests arrive together
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx <= '0;
      wr_op <= 1'b0;
      wait_cnt <= '0;
      beat <= '0;
      for (int i = 0; i < LINES; i++)
        for (int j = 0; j < 4; j++)
          mem[i][j] <= '0;
    end else begin
      state <= next;
      if (state == IDLE && (read_i || write_i)) begin
        idx <= address_i[5 +: IW];
        wr_op <= !read_i;
        wait_cnt <= 4'(LATENCY - 1);
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      beat <= resp_o ? beat + 2'd1 : 2'd0;
      if (state == WBURST) mem[idx][beat] <= burst_i;
    end
  end
endmodule

// File: tb/tb_burst_mem_responder.sv
// tb_burst_mem_responder: two responders (latency 3 and 0) against a transaction-timeline model
module tb_burst_mem_responder;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rd [2] = '{1'b0, 1'b0};
  logic wr [2] = '{1'b0, 1'b0};
  logic [31:0] ad [2] = '{32'd0, 32'd0};
  logic [63:0] bi [2] = '{64'd0, 64'd0};
  logic [63:0] bo [2];
  logic rs [2];
  logic bz [2];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  burst_mem_responder #(.LINES(16), .LATENCY(3)) u0 (
    .clk(clk), .reset_n(reset_n), .read_i(rd[0]), .write_i(wr[0]), .address_i(ad[0]),
    .burst_i(bi[0]), .burst_o(bo[0]), .resp_o(rs[0]), .busy_o(bz[0]));
  burst_mem_responder #(.LINES(16), .LATENCY(0)) u1 (
    .clk(clk), .reset_n(reset_n), .read_i(rd[1]), .write_i(wr[1]), .address_i(ad[1]),
    .burst_i(bi[1]), .burst_o(bo[1]), .resp_o(rs[1]), .busy_o(bz[1]));

  function automatic void chk(string nm, logic [255:0] a, logic [255:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, a, e);
    end
  endfunction

  function automatic int lat(int l);
    return l == 0 ? 3 : 0;
  endfunction

  function automatic logic [255:0] rnd256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // model: t counts cycles since acceptance; beats occupy t = L+1..L+4, DONE is t = L+5
  bit act [2];
  bit opw [2];
  bit [3:0] lin [2];
  int t [2];
  bit [63:0] mm [2][16][4];
  always @(posedge clk or negedge reset_n) begin
    for (int l = 0; l < 2; l++) begin
      if (!reset_n) begin
        act[l] <= 1'b0;
        t[l] <= 0;
        for (int i = 0; i < 16; i++)
          for (int j = 0; j < 4; j++)
            mm[l][i][j] <= '0;
      end else if (act[l]) begin
        if (opw[l] && t[l] > lat(l) && t[l] <= lat(l) + 4) mm[l][lin[l]][t[l] - lat(l) - 1] <= bi[l];
        if (t[l] == lat(l) + 5) act[l] <= 1'b0;
        else t[l] <= t[l] + 1;
      end else if (rd[l] || wr[l]) begin
        act[l] <= 1'b1;
        opw[l] <= !rd[l];
        lin[l] <= ad[l][8:5];
        t[l] <= 1;
      end
    end
  end

  always @(negedge clk or negedge reset_n) begin
    #1;
    for (int l = 0; l < 2; l++) begin
      logic er;
      int k;
      logic [63:0] eb;
      er = act[l] && t[l] > lat(l) && t[l] <= lat(l) + 4;
      k = er ? t[l] - lat(l) - 1 : 0;
      eb = (er && !opw[l]) ? mm[l][lin[l]][k] : 64'd0;
      chk(l == 0 ? "resp_l3" : "resp_l0", 256'(rs[l]), 256'(er));
      chk(l == 0 ? "busy_l3" : "busy_l0", 256'(bz[l]), 256'(act[l]));
      chk(l == 0 ? "burst_l3" : "burst_l0", 256'(bo[l]), 256'(eb));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // initiator: holds the request until the 4th resp, advancing write data after each resp
  task automatic txn(input int l, input bit r, input bit w, input logic [31:0] a, input logic [255:0] d,
                     input bit keep, input bit drop, input bit rst_mid,
                     output logic [255:0] cap, output int first, output int nbusy);
    int n, cyc;
    n = 0;
    cyc = -1;
    first = -1;
    nbusy = 0;
    cap = '0;
    rd[l] = r;
    wr[l] = w;
    ad[l] = a;
    bi[l] = d[63:0];
    while (n < 4) begin
      @(negedge clk);
      cyc++;
      if (cyc > 40) begin
        $display("FAIL txn_timeout lane %0d got %0d resp want 4", l, n);
        $fatal(1, "stalled");
      end
      if (bz[l]) nbusy++;
      if (rs[l]) begin
        if (first < 0) first = cyc;
        cap[64*n +: 64] = bo[l];
        n++;
      end
      @(posedge clk);
      #1;
      if (n == 4) begin
        if (!keep) begin
          rd[l] = 1'b0;
          wr[l] = 1'b0;
        end
      end else begin
        bi[l] = d[64*n +: 64];
        if (n >= 1) begin
          ad[l] = $urandom();
          if (drop) rd[l] = 1'b0;
        end
        if (rst_mid && n == 2) begin
          #2 reset_n = 1'b0;
          #1;
          chk("rst_resp", 256'(rs[l]), 256'd0);
          chk("rst_busy", 256'(bz[l]), 256'd0);
          chk("rst_burst", 256'(bo[l]), 256'd0);
          rd[l] = 1'b0;
          wr[l] = 1'b0;
          @(negedge clk);
          #2 reset_n = 1'b1;
          @(posedge clk);
          #1;
          break;
        end
      end
    end
  endtask

  initial begin
    logic [255:0] dd, ee, c;
    int f, nb, l;
    bit kp;
    dd = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    ee = rnd256();
    #11;
    chk("reset_busy", 256'(bz[0]), 256'd0);
    chk("reset_resp", 256'(rs[0]), 256'd0);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    txn(0, 1'b0, 1'b1, 32'h0000_0040, dd, 1'b0, 1'b0, 1'b0, c, f, nb);
    chk("wr_first_resp", 256'(f), 256'd4);
    chk("wr_busy_cycles", 256'(nb), 256'd7);
    idle(2);
    chk("model_beat0", 256'(mm[0][2][0]), 256'h1111_1111_1111_1111);
    chk("model_beat3", 256'(mm[0][2][3]), 256'h4444_4444_4444_4444);
    txn(0, 1'b1, 1'b0, 32'h0000_0040, '0, 1'b0, 1'b0, 1'b0, c, f, nb);
    chk("rd_back", c, dd);
    chk("rd_first_resp", 256'(f), 256'd4);
    idle(1);
    txn(0, 1'b1, 1'b0, 32'h0000_0100, '0, 1'b0, 1'b0, 1'b0, c, f, nb);
    chk("rd_unwritten", c, 256'd0);
    @(negedge clk);
    chk("done_busy", 256'(bz[0]), 256'd1);
    chk("done_resp", 256'(rs[0]), 256'd0);
    @(negedge clk);
    chk("after_done_busy", 256'(bz[0]), 256'd0);
    @(posedge clk);
    #1;
    txn(0, 1'b1, 1'b0, 32'h0000_0440, '0, 1'b0, 1'b0, 1'b0, c, f, nb);
    chk("rd_alias_440", c, dd);
    idle(1);
    txn(0, 1'b1, 1'b0, 32'h0000_005F, '0, 1'b0, 1'b0, 1'b0, c, f, nb);
    chk("rd_alias_05f", c, dd);
    idle(1);
    txn(0, 1'b1, 1'b1, 32'h0000_0080, ee, 1'b0, 1'b0, 1'b0, c, f, nb);
    chk("rd_wins", c, 256'd0);
    idle(1);
    txn(0, 1'b1, 1'b0, 32'h0000_0080, '0, 1'b0, 1'b0, 1'b0, c, f, nb);
    chk("write_ignored", c, 256'd0);
    idle(1);
    txn(0, 1'b1, 1'b0, 32'h0000_0040, '0, 1'b0, 1'b1, 1'b0, c, f, nb);
    chk("rd_drop_req", c, dd);
    idle(1);
    txn(1, 1'b0, 1'b1, 32'h0000_0040, ee, 1'b1, 1'b0, 1'b0, c, f, nb);
    chk("lat0_first_resp", 256'(f), 256'd1);
    txn(1, 1'b1, 1'b0, 32'h0000_0040, '0, 1'b0, 1'b0, 1'b0, c, f, nb);
    chk("lat0_b2b_busy", 256'(nb), 256'd5);
    chk("lat0_rd_back", c, ee);
    idle(1);
    txn(0, 1'b0, 1'b1, 32'h0000_0060, dd, 1'b0, 1'b0, 1'b1, c, f, nb);
    txn(0, 1'b1, 1'b0, 32'h0000_0060, '0, 1'b0, 1'b0, 1'b0, c, f, nb);
    chk("rst_line_zero", c, 256'd0);
    txn(1, 1'b1, 1'b0, 32'h0000_0040, '0, 1'b0, 1'b0, 1'b0, c, f, nb);
    chk("rst_other_zero", c, 256'd0);
    idle(1);
    l = 0;
    kp = 1'b0;
    for (int i = 0; i < 60; i++) begin
      int op;
      bit nk;
      if (!kp) l = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 2));
      nk = (i < 59) && ($urandom_range(0, 3) == 0);
      txn(l, op != 1, op != 0, $urandom() & 32'h0000_03FF, rnd256(), nk, 1'b0, 1'b0, c, f, nb);
      kp = nk;
      if (!kp) idle(int'($urandom_range(0, 2)));
    end
    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
